// File: rtl/hazard3_uart_dtm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard3_uart_dtm_pkg
// Description : Shared opcodes, status bytes and FSM state encoding for the
//               UART DTM command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard3_uart_dtm_pkg;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_ERR    = 8'h01;

    localparam logic [2:0] S_OPC     = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_WDATA   = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_TXD     = 3'd5;
    localparam logic [2:0] S_TXS     = 3'd6;

endpackage
`default_nettype wire

// File: rtl/hazard3_uart_dtm_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : hazard3_uart_dtm_cmd_seq
// Description : Turns RX FIFO command bytes into DMI requests and streams the
//               DMI response back into the TX FIFO. Optional idle abort of
//               partial commands via HAZARD3_UART_DTM_IDLE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard3_uart_dtm_cmd_seq
    import hazard3_uart_dtm_pkg::*;
#(
    parameter int ABITS          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [7:0]       rx_rdata,
    input  logic             rx_rvld,
    output logic             rx_rrdy,

    output logic [7:0]       tx_wdata,
    output logic             tx_wvld,
    input  logic             tx_wrdy,

    output logic             dmi_req_vld,
    input  logic             dmi_req_rdy,
    output logic             dmi_req_write,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_wdata,
    input  logic             dmi_resp_vld,
    input  logic [31:0]      dmi_resp_rdata,
    input  logic             dmi_resp_err,

    output logic             busy
);

    localparam logic [15:0] C_TIMEOUT = TIMEOUT_CYCLES[15:0];

    logic [2:0]  r_state;
    logic [1:0]  r_cnt;
    logic [23:0] r_resp;
    logic        r_err;

    logic        w_pop;
    logic        w_push;
    logic        w_rx_state;
    logic        w_timeout;

    assign w_pop      = rx_rvld && rx_rrdy;
    assign w_push     = tx_wvld && tx_wrdy;
    assign w_rx_state = (r_state == S_ADDR) || (r_state == S_WDATA);

`ifdef HAZARD3_UART_DTM_IDLE_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    assign w_timeout = w_rx_state && (r_to_cnt == C_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= 16'd0;
        end else if (w_pop || (r_state == S_OPC) || w_timeout) begin
            r_to_cnt <= 16'd0;
        end else if (w_rx_state && !rx_rvld && (r_to_cnt != 16'hffff)) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^C_TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_OPC;
            r_cnt         <= 2'd0;
            r_resp        <= 24'd0;
            r_err         <= 1'b0;
            rx_rrdy       <= 1'b0;
            tx_wvld       <= 1'b0;
            tx_wdata      <= 8'h00;
            dmi_req_vld   <= 1'b0;
            dmi_req_write <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_wdata <= 32'd0;
            busy          <= 1'b0;
        end else begin
            case (r_state)
                S_OPC: begin
                    rx_rrdy <= 1'b1;
                    // Unknown opcodes are consumed silently so the host can resync
                    if (w_pop && ((rx_rdata == CMD_READ) || (rx_rdata == CMD_WRITE))) begin
                        dmi_req_write <= (rx_rdata == CMD_WRITE);
                        r_state       <= S_ADDR;
                        busy          <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_pop) begin
                        dmi_req_addr <= rx_rdata[ABITS-1:0];
                        r_cnt        <= 2'd0;
                        if (dmi_req_write) begin
                            r_state <= S_WDATA;
                        end else begin
                            r_state     <= S_REQ;
                            rx_rrdy     <= 1'b0;
                            dmi_req_vld <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_OPC;
                        busy    <= 1'b0;
                    end
                end
                S_WDATA: begin
                    if (w_pop) begin
                        // LSB-first bytes shift down so d0 lands in [7:0] after four pops
                        dmi_req_wdata <= {rx_rdata, dmi_req_wdata[31:8]};
                        r_cnt         <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state     <= S_REQ;
                            rx_rrdy     <= 1'b0;
                            dmi_req_vld <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_OPC;
                        busy    <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (dmi_req_rdy) begin
                        dmi_req_vld <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmi_resp_vld) begin
                        r_err   <= dmi_resp_err;
                        r_resp  <= dmi_resp_rdata[31:8];
                        r_cnt   <= 2'd0;
                        tx_wvld <= 1'b1;
                        if (dmi_req_write) begin
                            tx_wdata <= dmi_resp_err ? ST_ERR : ST_OK;
                            r_state  <= S_TXS;
                        end else begin
                            tx_wdata <= dmi_resp_rdata[7:0];
                            r_state  <= S_TXD;
                        end
                    end
                end
                S_TXD: begin
                    if (w_push) begin
                        r_cnt  <= r_cnt + 2'd1;
                        r_resp <= {8'h00, r_resp[23:8]};
                        if (r_cnt == 2'd3) begin
                            tx_wdata <= r_err ? ST_ERR : ST_OK;
                            r_state  <= S_TXS;
                        end else begin
                            tx_wdata <= r_resp[7:0];
                        end
                    end
                end
                S_TXS: begin
                    if (w_push) begin
                        tx_wvld <= 1'b0;
                        rx_rrdy <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_OPC;
                    end
                end
                default: begin
                    r_state     <= S_OPC;
                    rx_rrdy     <= 1'b1;
                    tx_wvld     <= 1'b0;
                    dmi_req_vld <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard3_uart_dtm_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard3_uart_dtm_cmd_seq
// Description : Directed self-checking bench for the UART DTM command
//               sequencer (FIFO and DMI models driven from the bench).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard3_uart_dtm_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_rdata = 8'h00;
    logic        rx_rvld = 1'b0;
    logic        rx_rrdy;
    logic [7:0]  tx_wdata;
    logic        tx_wvld;
    logic        tx_wrdy = 1'b1;
    logic        dmi_req_vld;
    logic        dmi_req_rdy = 1'b1;
    logic        dmi_req_write;
    logic [7:0]  dmi_req_addr;
    logic [31:0] dmi_req_wdata;
    logic        dmi_resp_vld = 1'b0;
    logic [31:0] dmi_resp_rdata = 32'd0;
    logic        dmi_resp_err = 1'b0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  rx_buf[$];
    int          rx_idx = 0;
    logic [7:0]  tx_got[$];
    logic        req_wr_q[$];
    logic [7:0]  req_addr_q[$];
    logic [31:0] req_wd_q[$];
    int          req_cnt = 0;
    int          resp_cnt = 0;

    logic        rdy_en = 1'b1;
    logic        tx_toggle = 1'b0;
    logic [31:0] cfg_rdata = 32'd0;
    logic        cfg_err = 1'b0;

    hazard3_uart_dtm_cmd_seq #(
        .ABITS          (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_rdata       (rx_rdata),
        .rx_rvld        (rx_rvld),
        .rx_rrdy        (rx_rrdy),
        .tx_wdata       (tx_wdata),
        .tx_wvld        (tx_wvld),
        .tx_wrdy        (tx_wrdy),
        .dmi_req_vld    (dmi_req_vld),
        .dmi_req_rdy    (dmi_req_rdy),
        .dmi_req_write  (dmi_req_write),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_wdata  (dmi_req_wdata),
        .dmi_resp_vld   (dmi_resp_vld),
        .dmi_resp_rdata (dmi_resp_rdata),
        .dmi_resp_err   (dmi_resp_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Handshake observers: every completed transfer is recorded at the active edge
    always @(posedge clk) begin
        if (rst_n && rx_rvld && rx_rrdy) rx_idx <= rx_idx + 1;
        if (rst_n && tx_wvld && tx_wrdy) tx_got.push_back(tx_wdata);
        if (rst_n && dmi_req_vld && dmi_req_rdy) begin
            req_wr_q.push_back(dmi_req_write);
            req_addr_q.push_back(dmi_req_addr);
            req_wd_q.push_back(dmi_req_wdata);
            req_cnt <= req_cnt + 1;
        end
    end

    always @(negedge clk) begin
        rx_rvld     = (rx_idx < rx_buf.size());
        rx_rdata    = rx_rvld ? rx_buf[rx_idx] : 8'h00;
        tx_wrdy     = tx_toggle ? ~tx_wrdy : 1'b1;
        dmi_req_rdy = rdy_en;
        if (req_cnt > resp_cnt) begin
            dmi_resp_vld   = 1'b1;
            dmi_resp_rdata = cfg_rdata;
            dmi_resp_err   = cfg_err;
            resp_cnt       = resp_cnt + 1;
        end else begin
            dmi_resp_vld   = 1'b0;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf.push_back(b);
    endtask

    task automatic wait_tx(input string tag, input int base, input int n);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tx_got.size() >= base + n) break;
        end
        repeat (8) @(negedge clk);
        check_vec({tag, "_txcnt"}, 32'(tx_got.size() - base), 32'(n));
    endtask

    task automatic check_tx(input string tag, input int pos, input logic [7:0] exp);
        logic [31:0] got;
        got = (pos < tx_got.size()) ? {24'd0, tx_got[pos]} : 32'h100;
        check_vec(tag, got, {24'd0, exp});
    endtask

    task automatic check_resp5(input string tag, input int base, input logic [31:0] rd, input logic [7:0] st);
        for (int i = 0; i < 4; i++) check_tx({tag, "_data"}, base + i, rd[8*i +: 8]);
        check_tx({tag, "_status"}, base + 4, st);
    endtask

    task automatic check_req(input string tag, input int idx, input logic wr,
                             input logic [7:0] addr, input logic [31:0] wd);
        if (idx < req_addr_q.size()) begin
            check_vec({tag, "_write"}, 32'(req_wr_q[idx]), 32'(wr));
            check_vec({tag, "_addr"}, 32'(req_addr_q[idx]), 32'(addr));
            if (wr) check_vec({tag, "_wdata"}, req_wd_q[idx], wd);
        end else begin
            check_vec({tag, "_present"}, 32'(req_addr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic wait_rx_drained(input string tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rx_idx >= rx_buf.size()) break;
        end
        check_vec({tag, "_drained"}, 32'(rx_idx), 32'(rx_buf.size()));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_vec({tag, "_ctl"}, {27'd0, rx_rrdy, tx_wvld, dmi_req_vld, dmi_req_write, busy}, 32'd0);
        check_vec({tag, "_txd"}, {24'd0, tx_wdata}, 32'd0);
        check_vec({tag, "_addr"}, {24'd0, dmi_req_addr}, 32'd0);
        check_vec({tag, "_wdata"}, dmi_req_wdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb0;
        int rq0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("idle_rrdy", 32'(rx_rrdy), 32'd1);

        // Read of 0x05
        tb0 = tx_got.size(); rq0 = req_addr_q.size();
        cfg_rdata = 32'hDEADBEEF; cfg_err = 1'b0;
        push(8'h01); push(8'h05);
        wait_tx("read", tb0, 5);
        check_vec("read_nreq", 32'(req_addr_q.size() - rq0), 32'd1);
        check_req("read", rq0, 1'b0, 8'h05, 32'd0);
        check_resp5("read", tb0, 32'hDEADBEEF, 8'h00);
        check_vec("read_busy", 32'(busy), 32'd0);

        // Write 0x12345678 to 0x10, DM reports error
        tb0 = tx_got.size(); rq0 = req_addr_q.size();
        cfg_rdata = 32'h0; cfg_err = 1'b1;
        push(8'h02); push(8'h10); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        wait_tx("write", tb0, 1);
        check_vec("write_nreq", 32'(req_addr_q.size() - rq0), 32'd1);
        check_req("write", rq0, 1'b1, 8'h10, 32'h12345678);
        check_tx("write_status", tb0, 8'h01);

        // Request and TX backpressure
        tb0 = tx_got.size(); rq0 = req_addr_q.size();
        rdy_en = 1'b0;
        cfg_rdata = 32'h11223344; cfg_err = 1'b0;
        push(8'h01); push(8'h2A);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dmi_req_vld) break;
        end
        check_vec("bp_vld_seen", 32'(dmi_req_vld), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_vec("bp_hold_vld", 32'(dmi_req_vld), 32'd1);
            check_vec("bp_hold_addr", {24'd0, dmi_req_addr}, 32'h2A);
            check_vec("bp_hold_wr", 32'(dmi_req_write), 32'd0);
            check_vec("bp_hold_wdata", dmi_req_wdata, 32'h12345678);
        end
        tx_toggle = 1'b1;
        rdy_en = 1'b1;
        wait_tx("bp", tb0, 5);
        tx_toggle = 1'b0;
        check_vec("bp_nreq", 32'(req_addr_q.size() - rq0), 32'd1);
        check_resp5("bp", tb0, 32'h11223344, 8'h00);

        // Garbage bytes ahead of a read
        tb0 = tx_got.size(); rq0 = req_addr_q.size();
        cfg_rdata = 32'hCAFEF00D; cfg_err = 1'b0;
        push(8'h7F); push(8'h00); push(8'h01); push(8'h03);
        wait_tx("garb", tb0, 5);
        check_vec("garb_nreq", 32'(req_addr_q.size() - rq0), 32'd1);
        check_req("garb", rq0, 1'b0, 8'h03, 32'd0);
        check_resp5("garb", tb0, 32'hCAFEF00D, 8'h00);

        // Reset in the middle of a write command
        tb0 = tx_got.size(); rq0 = req_addr_q.size();
        push(8'h02); push(8'h10); push(8'h34);
        wait_rx_drained("rstmid");
        check_vec("rstmid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstmid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cfg_rdata = 32'h00000000; cfg_err = 1'b0;
        push(8'h01); push(8'h02);
        wait_tx("rstrd", tb0, 5);
        check_vec("rstrd_nreq", 32'(req_addr_q.size() - rq0), 32'd1);
        check_req("rstrd", rq0, 1'b0, 8'h02, 32'd0);
        check_resp5("rstrd", tb0, 32'h00000000, 8'h00);

`ifdef HAZARD3_UART_DTM_IDLE_TIMEOUT_EN
        // Partial write abandoned by the idle timeout
        tb0 = tx_got.size(); rq0 = req_addr_q.size();
        push(8'h02); push(8'h10);
        wait_rx_drained("tmo");
        repeat (25) @(negedge clk);
        check_vec("tmo_busy", 32'(busy), 32'd0);
        check_vec("tmo_rrdy", 32'(rx_rrdy), 32'd1);
        check_vec("tmo_nreq", 32'(req_addr_q.size() - rq0), 32'd0);
        check_vec("tmo_ntx", 32'(tx_got.size() - tb0), 32'd0);
        cfg_rdata = 32'h00000005;
        push(8'h01); push(8'h07);
        wait_tx("tmord", tb0, 5);
        check_req("tmord", rq0, 1'b0, 8'h07, 32'd0);
        check_resp5("tmord", tb0, 32'h00000005, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard3_uart_dtm_cmd_seq.md
Name: hazard3_uart_dtm_cmd_seq

Overview:
- Command sequencer between the UART DTM byte FIFOs and the Debug Module Interface (DMI).
- Pops command bytes from the RX FIFO, assembles DMI read/write requests, issues them with a valid/ready handshake, and pushes response bytes into the TX FIFO.
- Sits between the RX/TX sync FIFOs (instantiated outside this block) and the DM's DMI port; it owns all sequencing of both FIFOs.

Parameters:
- ABITS, 8, DMI address width; 1..8, carried in one address byte (upper byte bits ignored).
- TIMEOUT_CYCLES, 65535, idle cycles before a partial command is aborted (only with the optional feature); 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_rdata  in  8  RX FIFO head byte
- rx_rvld  in  1  RX FIFO non-empty
- rx_rrdy  out  1  pop RX FIFO head
- tx_wdata  out  8  byte to TX FIFO
- tx_wvld  out  1  TX push request
- tx_wrdy  in  1  TX FIFO not full
- dmi_req_vld  out  1  DMI request valid
- dmi_req_rdy  in  1  DMI request accepted
- dmi_req_write  out  1  1 = write, 0 = read
- dmi_req_addr  out  ABITS  DMI register address
- dmi_req_wdata  out  32  write data
- dmi_resp_vld  in  1  one-cycle response strobe; always accepted
- dmi_resp_rdata  in  32  read data, valid with dmi_resp_vld
- dmi_resp_err  in  1  error flag, valid with dmi_resp_vld
- busy  out  1  high when the FSM is not in S_OPC

Behaviour:
- Protocol, multi-byte fields LSB first:
  - READ: 0x01, addr → response: 4 data bytes, then status.
  - WRITE: 0x02, addr, d0..d3 → response: status only.
  - Status byte: 0x00 OK, 0x01 DMI error.
  - Any other opcode is popped and discarded with no response (resync point).
- Reset values: rx_rrdy=0, tx_wvld=0, tx_wdata=0, dmi_req_vld=0, dmi_req_write=0, dmi_req_addr=0, dmi_req_wdata=0, busy=0. The FSM resets to S_OPC, the byte counter to 0 and the response shift register to 0.
- rx_rrdy is asserted only in S_OPC, S_ADDR and S_WDATA; a byte is consumed only on the cycle where rx_rvld && rx_rrdy.
- tx_wvld is asserted only in S_TXD and S_TXS; a byte is pushed only when tx_wvld && tx_wrdy. tx_wvld and tx_wdata stay stable until accepted.
- dmi_req_* are registered and held stable from assertion until dmi_req_rdy; no combinational path from dmi_req_rdy to dmi_req_vld.
- FSM states and transitions:
  - S_OPC: byte 0x01 or 0x02 → latch write flag, go to S_ADDR; any other byte is dropped.
  - S_ADDR: byte → dmi_req_addr = byte[ABITS-1:0]; write → S_WDATA with cnt=0; read → S_REQ.
  - S_WDATA: byte → wdata[8*cnt +: 8], cnt++; after cnt==3 is consumed → S_REQ.
  - S_REQ: dmi_req_vld=1; on dmi_req_rdy → S_WAIT.
  - S_WAIT: on dmi_resp_vld → capture rdata and err. Read → S_TXD with cnt=0; write → S_TXS.
  - S_TXD: emit rdata byte cnt on each accepted push; after cnt==3 → S_TXS.
  - S_TXS: emit status; on accept → S_OPC.
- Minimum latencies: one byte per cycle when FIFOs allow. First dmi_req_vld is asserted the cycle after the last command byte is popped. First response byte is presented the cycle after dmi_resp_vld.
- dmi_resp_vld outside S_WAIT is ignored; the DM guarantees one response per request.
- RX empty or TX full: the FSM stalls in its current state indefinitely with no lost or duplicated bytes.
- Reset mid-operation: immediate return to S_OPC with all outputs at reset values. A partially received command is lost; the host resyncs by sending opcodes.
- cnt is 2 bits and wraps only through state exit, never mid-field.

Optional Feature:
- Macro HAZARD3_UART_DTM_IDLE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on any RX pop and on entry to S_OPC, and increments while the FSM is in S_ADDR or S_WDATA with rx_rvld=0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM returns to S_OPC, the partial command is discarded and no response is sent.
  - S_REQ, S_WAIT and TX states never time out.
- Undefined: no counter; S_ADDR and S_WDATA wait forever; TIMEOUT_CYCLES is unused.

Decomposition:
- Package hazard3_uart_dtm_pkg holds:
  - Opcode constants CMD_READ=8'h01 and CMD_WRITE=8'h02.
  - Status constants ST_OK=8'h00 and ST_ERR=8'h01.
  - FSM state encoding (3-bit localparams S_OPC..S_TXS).
- No sub-module; the FSM, 2-bit byte counter, 32-bit shift/capture registers and optional timeout counter are all local. FIFOs are instantiated by the parent.

Test Plan:
- Read: RX bytes 01 05, DM returns rdata=0xDEADBEEF, err=0 → one request (write=0, addr=0x05); TX bytes EF BE AD DE 00.
- Write: RX 02 10 78 56 34 12 → request write=1, addr=0x10, wdata=0x12345678; on response err=1, TX byte 01.
- Backpressure: dmi_req_rdy held low 10 cycles and tx_wrdy toggled every cycle → request fields stable throughout; TX byte sequence exact with no duplicates.
- Garbage: RX 7F 00 01 03 → 7F and 00 dropped; read of addr 0x03 issued; exactly 5 TX bytes.
- Reset mid-write: rst_n pulsed after 02 10 34 → all outputs 0; then RX 01 02 → a clean read of addr 0x02 is issued.
- Timeout (macro defined, TIMEOUT_CYCLES=20): RX 02 10 then 25 idle cycles → FSM back in S_OPC, busy=0, no DMI request, no TX bytes.
